// File: rtl/lcd_frame_dma_reader.sv
// lcd_frame_dma_reader: AXI3 burst-read master that streams one LCD frame
// from DDR into the LCD pixel FIFO. It issues fixed 16-beat, 32-bit bursts,
// one outstanding at a time, and only when the FIFO can take a whole burst.
module lcd_frame_dma_reader #(
    parameter int unsigned BURSTS_PER_FRAME = 4080,
    parameter int unsigned FIFO_DEPTH       = 512
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        FRAME_START,
    input  logic [29:0] BUFFER_START_ADDRESS,
    input  logic [9:0]  FIFO_COUNT,
    output logic        FIFO_WR_EN,
    output logic [31:0] FIFO_WR_DATA,
    output logic        BUSY,
    output logic        FRAME_DONE,
    output logic        PROTOCOL_ERR,
    input  logic        m00_axi_arready,
    output logic        m00_axi_arvalid,
    output logic [31:0] m00_axi_araddr,
    output logic [3:0]  m00_axi_arlen,
    input  logic        m00_axi_rvalid,
    input  logic        m00_axi_rlast,
    input  logic [31:0] m00_axi_rdata,
    output logic        m00_axi_rready
);

    localparam int unsigned    BLW         = $clog2(BURSTS_PER_FRAME + 1);
    localparam logic [BLW-1:0] BURSTS_INIT = BLW'(BURSTS_PER_FRAME);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ADDR,
        S_DATA,
        S_SETTLE
    } state_e;

    state_e         state_q;
    logic [29:0]    addr_q;
    logic [BLW-1:0] bursts_left_q;
    logic [3:0]     beat_q;
    logic           restart_pending_q;
    logic           busy_q;
    logic           frame_done_q;
    logic           perr_q;
    logic           arvalid_q;
    logic           rready_q;
    logic           wr_en_q;
    logic [31:0]    wr_data_q;

    logic fifo_room;
    logic last_beat;
    logic restart_now;

    // Room check, burst-end detection and restart request decode
    always_comb begin
        fifo_room   = (32'(FIFO_COUNT) + 32'd16) <= FIFO_DEPTH;
        last_beat   = m00_axi_rlast || (beat_q == 4'hF);
        restart_now = restart_pending_q || FRAME_START;
    end

    assign FIFO_WR_EN      = wr_en_q;
    assign FIFO_WR_DATA    = wr_data_q;
    assign BUSY            = busy_q;
    assign FRAME_DONE      = frame_done_q;
    assign PROTOCOL_ERR    = perr_q;
    assign m00_axi_arvalid = arvalid_q;
    assign m00_axi_araddr  = {addr_q, 2'b00};
    assign m00_axi_arlen   = 4'hF;
    assign m00_axi_rready  = rready_q;

    // Frame sequencer: address/burst bookkeeping and all registered outputs
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q           <= S_IDLE;
            addr_q            <= '0;
            bursts_left_q     <= '0;
            beat_q            <= '0;
            restart_pending_q <= 1'b0;
            busy_q            <= 1'b0;
            frame_done_q      <= 1'b0;
            perr_q            <= 1'b0;
            arvalid_q         <= 1'b0;
            rready_q          <= 1'b0;
            wr_en_q           <= 1'b0;
            wr_data_q         <= '0;
        end else begin
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (FRAME_START) begin
                        addr_q        <= BUFFER_START_ADDRESS;
                        bursts_left_q <= BURSTS_INIT;
                        busy_q        <= 1'b1;
                        state_q       <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    // No burst is in flight here, so a new frame request
                    // simply replaces the current one.
                    if (FRAME_START) begin
                        addr_q        <= BUFFER_START_ADDRESS;
                        bursts_left_q <= BURSTS_INIT;
                    end
                    if (fifo_room) begin
                        arvalid_q <= 1'b1;
                        state_q   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (FRAME_START) restart_pending_q <= 1'b1;
                    if (m00_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        beat_q    <= '0;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (FRAME_START) restart_pending_q <= 1'b1;
                    if (m00_axi_rvalid) begin
                        wr_en_q   <= 1'b1;
                        wr_data_q <= m00_axi_rdata;
                        beat_q    <= beat_q + 4'd1;
                        if (last_beat) begin
                            if (m00_axi_rlast != (beat_q == 4'hF)) perr_q <= 1'b1;
                            addr_q        <= addr_q + 30'd16;
                            bursts_left_q <= bursts_left_q - BLW'(1);
                            rready_q      <= 1'b0;
                            frame_done_q  <= (bursts_left_q == BLW'(1)) && !restart_now;
                            state_q       <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (restart_now) begin
                        addr_q            <= BUFFER_START_ADDRESS;
                        bursts_left_q     <= BURSTS_INIT;
                        restart_pending_q <= 1'b0;
                        state_q           <= S_CHECK;
                    end else if (bursts_left_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_CHECK;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/lcd_frame_dma_reader.md
# lcd_frame_dma_reader

- AXI3 burst-read master that streams one LCD frame per `FRAME_START` pulse from DDR into the pixel FIFO of the LCD controller.
- Sits directly upstream of the LCD pixel FIFO and RGB output stage; its AXI3 read port connects to the HP/GP slave port.
- Issues fixed 16-beat, 32-bit bursts, one outstanding at a time, only when the FIFO has room for the whole burst.
- Holds `m00_axi_rready` high for the entire data phase.

## Interface
- `BURSTS_PER_FRAME`, default 4080: 16-word bursts per frame (480×272×16 bpp / 32 / 16).
- `FIFO_DEPTH`, default 512: pixel FIFO depth in 32-bit words.
- `CLK` in 1: DMA clock. One clock; reset is asynchronous and active-low.
- `RESETN` in 1: asynchronous active-low reset.
- `FRAME_START` in 1: single-cycle pulse in the `CLK` domain that starts a frame read.
- `BUFFER_START_ADDRESS` in 30: frame base, in 32-bit word units; sampled on an accepted `FRAME_START`.
- `FIFO_COUNT` in 10: FIFO occupancy in words, lagging writes by ≤1 cycle.
- `FIFO_WR_EN` out 1: FIFO write strobe.
- `FIFO_WR_DATA` out 32: FIFO write data.
- `BUSY` out 1: frame read in progress.
- `FRAME_DONE` out 1: one-cycle pulse, coincident with the last frame word's `FIFO_WR_EN`.
- `PROTOCOL_ERR` out 1: sticky flag for an `rlast` mismatch.
- `m00_axi_arready` in 1: AXI3 read-address ready.
- `m00_axi_arvalid` out 1: AXI3 read-address valid.
- `m00_axi_araddr` out 32: burst byte address.
- `m00_axi_arlen` out 4: constant 4'hF.
- `m00_axi_rvalid` in 1: AXI3 read-data valid.
- `m00_axi_rlast` in 1: last beat of burst.
- `m00_axi_rdata` in 32: read data.
- `m00_axi_rready` out 1: read-data ready.

## Operation
- States:
  - IDLE: no frame active.
  - CHECK: waiting for FIFO room.
  - ADDR: address phase.
  - DATA: data phase.
  - SETTLE: one cycle after a burst.
- IDLE → CHECK on `FRAME_START`:
  - latch `addr_q` = `BUFFER_START_ADDRESS`;
  - `bursts_left` = `BURSTS_PER_FRAME`;
  - `BUSY` = 1.
- CHECK → ADDR when `FIFO_DEPTH − FIFO_COUNT ≥ 16`; otherwise stay in CHECK.
- ADDR:
  - `m00_axi_arvalid` = 1 and `m00_axi_araddr` = {`addr_q`, 2'b00}, both stable until `arready`;
  - → DATA on `arvalid & arready`.
- DATA:
  - `m00_axi_rready` = 1;
  - each `rvalid` beat is counted in a 4-bit `beat` counter and written to the FIFO;
  - on a beat with `rlast`: `addr_q` += 16, `bursts_left` −= 1, → SETTLE.
- SETTLE exits as follows:
  - `bursts_left == 0` → IDLE, `BUSY` = 0;
  - else → CHECK.
- SETTLE gives `FIFO_COUNT` time to reflect the final write.
- Address arithmetic: `addr_q` is 30 bits and wraps modulo 2^30. There is no 4 KB boundary check; frame bases are 64-byte aligned by software.
- `FRAME_START` while `BUSY`:
  - set `restart_pending`;
  - the current burst always completes (AXI bursts cannot be aborted) and its data is still written;
  - in SETTLE, if `restart_pending`: reload `addr_q` from `BUFFER_START_ADDRESS`, reload `bursts_left`, clear the flag, → CHECK;
  - `FRAME_DONE` is not pulsed for the aborted frame;
  - a pulse arriving in ADDR or CHECK takes effect immediately (CHECK) or after the burst (ADDR).
- `rlast` checking:
  - `rlast` on a beat other than the 16th, or no `rlast` on the 16th beat, sets `PROTOCOL_ERR`;
  - the burst then ends on whichever comes first, `rlast` or the 16th beat;
  - `PROTOCOL_ERR` clears only on reset.

## Timing
- Reset values: all outputs 0; `m00_axi_arlen` = 4'hF; state IDLE; `restart_pending` 0.
- Reset is asynchronous. Asserting it mid-burst drops `arvalid`/`rready` immediately. The AXI slave is reset from the same source.
- `FRAME_START` to first `arvalid`: 2 cycles when the FIFO has room (IDLE→CHECK→ADDR).
- `FIFO_WR_EN`/`FIFO_WR_DATA` are registered, 1 cycle after the accepted beat. There is no throttling, since room was reserved in CHECK.
- Burst end:
  - `FRAME_DONE` is high in the cycle after the final `rlast`;
  - `BUSY` falls 1 cycle after that (end of SETTLE).
- Burst turnaround with ready FIFO and `arready` = 1: accepted `rlast` → SETTLE → CHECK → ADDR = next `arvalid` 3 cycles later.
- `m00_axi_rready` is 0 outside DATA.

## Test plan
- **Small frame, zero-latency slave:**
  - stimulus: `BURSTS_PER_FRAME` = 4, base 0x2000_0000, slave with `arready` = 1 and data = address-derived;
  - required: 4 ARs at 0x8000_0000, 0x8000_0040, 0x8000_0080, 0x8000_00C0; 64 FIFO writes in order; one `FRAME_DONE`; `BUSY` low afterwards.
- **FIFO backpressure:**
  - stimulus: `FIFO_COUNT` held at 497;
  - required: no `arvalid`;
  - then `FIFO_COUNT` drops to 496: `arvalid` is asserted 1 cycle later.
- **Slow slave:**
  - stimulus: `arready` delayed 7 cycles, `rvalid` on alternate cycles;
  - required: `araddr` stable while `arvalid` is high; exactly 16 writes per burst.
- **Restart mid-burst:**
  - stimulus: `FRAME_START` at beat 5 of burst 2, new base 0x100;
  - required: burst 2 completes (16 writes); next AR at 0x400; no `FRAME_DONE` for the aborted frame.
- **Reset mid-burst:**
  - stimulus: `RESETN` low at beat 8;
  - required: all outputs 0 in the same cycle; after release, IDLE until the next `FRAME_START`.
- **Early rlast:**
  - stimulus: `rlast` on beat 10;
  - required: `PROTOCOL_ERR` = 1; next burst issued; flag stays set until reset.
